// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: opcode-aware multi-cycle sequencer for the single-issue CPU.
// One-hot state, memory wait/timeout handling, retired-instruction counter.
module cpu_seq_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             I_clk,
  input  logic             I_reset,
  input  logic [3:0]       I_opcode,
  input  logic             I_brtaken,
  input  logic             I_memack,
  output logic             O_enfetch,
  output logic             O_endec,
  output logic             O_enrgrd,
  output logic             O_enalu,
  output logic             O_enmem,
  output logic             O_enrgwr,
  output logic             O_memreq,
  output logic             O_memwe,
  output logic             O_irload,
  output logic             O_pcinc,
  output logic             O_pcload,
  output logic             O_illegal,
  output logic             O_halted,
  output logic             O_buserr,
  output logic [CNT_W-1:0] O_retired
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [6:0] {
    S_FETCH  = 7'b0000001,
    S_DECODE = 7'b0000010,
    S_REGRD  = 7'b0000100,
    S_ALU    = 7'b0001000,
    S_MEM    = 7'b0010000,
    S_WB     = 7'b0100000,
    S_HALT   = 7'b1000000
  } state_t;

  typedef enum logic [2:0] {
    C_NOP,
    C_ALU,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,
    C_HALT
  } cls_t;

  state_t            r_state;
  state_t            w_next;
  cls_t              r_cls;
  cls_t              w_cls;
  logic              w_bad_op;
  logic [WC_W-1:0]   r_wait;
  logic              r_buserr;
  logic [CNT_W-1:0]  r_retired;
  logic              w_memst;
  logic              w_tmo;
  logic              w_enter;
  logic              w_retire;

  always_comb begin
    w_cls    = C_NOP;
    w_bad_op = 1'b0;
    case (I_opcode)
      4'h0: w_cls = C_NOP;
      4'h1, 4'h2, 4'h3, 4'h4,
      4'h5, 4'h6, 4'h7: w_cls = C_ALU;
      4'h8: w_cls = C_LOAD;
      4'h9: w_cls = C_STORE;
      4'hA: w_cls = C_BRANCH;
      4'hB: w_cls = C_JUMP;
      4'hF: w_cls = C_HALT;
      default: begin
        w_cls    = C_NOP;
        w_bad_op = 1'b1;
      end
    endcase
  end

  assign w_memst = r_state[0] | r_state[4];
  // last permitted wait cycle ended without ack; a same-cycle ack wins
  assign w_tmo = w_memst && !I_memack &&
                 (r_wait == WC_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (I_memack)   w_next = S_DECODE;
        else if (w_tmo) w_next = S_HALT;
      end
      S_DECODE: begin
        case (w_cls)
          C_NOP:   w_next = S_FETCH;
          C_HALT:  w_next = S_HALT;
          default: w_next = S_REGRD;
        endcase
      end
      S_REGRD: w_next = S_ALU;
      S_ALU: begin
        case (r_cls)
          C_LOAD, C_STORE: w_next = S_MEM;
          C_ALU:           w_next = S_WB;
          default:         w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (I_memack)
          w_next = (r_cls == C_LOAD) ? S_WB : S_FETCH;
        else if (w_tmo)
          w_next = S_HALT;
      end
      S_WB:   w_next = S_FETCH;
      S_HALT: w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  assign w_enter  = (w_next != r_state) &&
                    (w_next == S_FETCH || w_next == S_MEM);
  assign w_retire = (w_next == S_FETCH) && (r_state != S_FETCH);

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      r_state   <= S_FETCH;
      r_cls     <= C_NOP;
      r_wait    <= '0;
      r_buserr  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE)
        r_cls <= w_cls;
      if (w_enter)
        r_wait <= '0;
      else if (w_memst && !I_memack)
        r_wait <= r_wait + WC_W'(1);
      if (w_tmo)
        r_buserr <= 1'b1;
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign O_enfetch = r_state[0];
  assign O_endec   = r_state[1];
  assign O_enrgrd  = r_state[2];
  assign O_enalu   = r_state[3];
  assign O_enmem   = r_state[4];
  assign O_enrgwr  = r_state[5];
  assign O_halted  = r_state[6];
  assign O_memreq  = w_memst;
  assign O_memwe   = r_state[4] && (r_cls == C_STORE);
  assign O_irload  = r_state[0] && I_memack;
  assign O_pcinc   = r_state[0] && I_memack;
  assign O_pcload  = r_state[3] &&
                     ((r_cls == C_JUMP) ||
                      ((r_cls == C_BRANCH) && I_brtaken));
  assign O_illegal = r_state[1] && w_bad_op;
  assign O_buserr  = r_buserr;
  assign O_retired = r_retired;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb_cpu_seq_ctrl: directed stimulus with a path-table reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_cpu_seq_ctrl;

  localparam int TO = 16;
  localparam int F = 0, D = 1, R = 2, A = 3, M = 4, W = 5, H = 6;

  logic I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  logic        I_reset, I_brtaken, I_memack;
  logic [3:0]  I_opcode;
  logic        O_enfetch, O_endec, O_enrgrd, O_enalu, O_enmem, O_enrgwr;
  logic        O_memreq, O_memwe, O_irload, O_pcinc, O_pcload;
  logic        O_illegal, O_halted, O_buserr;
  logic [15:0] O_retired;

  cpu_seq_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) u_dut (
    .I_clk(I_clk), .I_reset(I_reset), .I_opcode(I_opcode),
    .I_brtaken(I_brtaken), .I_memack(I_memack),
    .O_enfetch(O_enfetch), .O_endec(O_endec), .O_enrgrd(O_enrgrd),
    .O_enalu(O_enalu), .O_enmem(O_enmem), .O_enrgwr(O_enrgwr),
    .O_memreq(O_memreq), .O_memwe(O_memwe), .O_irload(O_irload),
    .O_pcinc(O_pcinc), .O_pcload(O_pcload), .O_illegal(O_illegal),
    .O_halted(O_halted), .O_buserr(O_buserr), .O_retired(O_retired)
  );

  // narrow-counter instance so wraparound is reachable in few cycles
  logic       w_rst, w_brt, w_ack;
  logic [3:0] w_op;
  logic       w_f, w_d, w_r, w_a, w_m, w_w, w_mr, w_mw, w_ir, w_pi;
  logic       w_pl, w_il, w_h, w_be;
  logic [3:0] w_ret;

  cpu_seq_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(4)) u_w (
    .I_clk(I_clk), .I_reset(w_rst), .I_opcode(w_op),
    .I_brtaken(w_brt), .I_memack(w_ack),
    .O_enfetch(w_f), .O_endec(w_d), .O_enrgrd(w_r),
    .O_enalu(w_a), .O_enmem(w_m), .O_enrgwr(w_w),
    .O_memreq(w_mr), .O_memwe(w_mw), .O_irload(w_ir),
    .O_pcinc(w_pi), .O_pcload(w_pl), .O_illegal(w_il),
    .O_halted(w_h), .O_buserr(w_be), .O_retired(w_ret)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: instruction paths as stage lists
  int   m_st = F;
  int   m_wait = 0;
  int   m_ret = 0;
  bit   m_err = 0;
  int   m_op = 0;
  bit   m_on = 0;
  int   m_path[$];

  task automatic m_advance();
    if (m_path.size() == 0) begin
      m_st = F;
      m_ret++;
      m_wait = 0;
    end else begin
      m_st = m_path.pop_front();
      if (m_st == M) m_wait = 0;
    end
  endtask

  always @(posedge I_clk) begin
    if (I_reset) begin
      m_st = F; m_wait = 0; m_ret = 0; m_err = 0; m_op = 0;
      m_path.delete();
    end else begin
      case (m_st)
        F, M: begin
          if (I_memack) begin
            if (m_st == F) m_st = D;
            else m_advance();
          end else if (m_wait == TO - 1) begin
            m_st = H;
            m_err = 1;
          end else m_wait++;
        end
        D: begin
          m_op = int'(I_opcode);
          m_path.delete();
          if (m_op >= 12 && m_op <= 14) m_op = 0;
          if (m_op >= 1 && m_op <= 7) m_path = '{R, A, W};
          else if (m_op == 8) m_path = '{R, A, M, W};
          else if (m_op == 9) m_path = '{R, A, M};
          else if (m_op == 10 || m_op == 11) m_path = '{R, A};
          if (m_op == 15) m_st = H;
          else m_advance();
        end
        R, A, W: m_advance();
        default: ;
      endcase
    end
  end

  always @(negedge I_clk) begin
    logic [13:0] e;
    logic [13:0] a;
    if (m_on) begin
      e = {m_st == F, m_st == D, m_st == R, m_st == A, m_st == M,
           m_st == W, (m_st == F || m_st == M),
           (m_st == M && m_op == 9),
           (m_st == F && I_memack), (m_st == F && I_memack),
           (m_st == A && (m_op == 11 || (m_op == 10 && I_brtaken))),
           (m_st == D && I_opcode >= 4'd12 && I_opcode <= 4'd14),
           m_st == H, m_err};
      a = {O_enfetch, O_endec, O_enrgrd, O_enalu, O_enmem, O_enrgwr,
           O_memreq, O_memwe, O_irload, O_pcinc, O_pcload,
           O_illegal, O_halted, O_buserr};
      chk("ctl", 32'(a), 32'(e));
      chk("retired", 32'(O_retired), m_ret & 32'hFFFF);
    end
  end

  task automatic cyc();
    @(posedge I_clk);
    #1;
  endtask

  task automatic until_fetch(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!O_enfetch && n < 40);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k;
    I_reset = 1; I_memack = 1; I_opcode = 0; I_brtaken = 0;
    w_rst = 1; w_ack = 1; w_op = 0; w_brt = 0;
    cyc();
    m_on = 1;
    cyc();
    chk("rst_fetch", O_enfetch, 1);
    chk("rst_memreq", O_memreq, 1);
    chk("rst_retired", O_retired, 0);
    chk("rst_buserr", O_buserr, 0);
    I_reset = 0;

    I_opcode = 4'h1;
    until_fetch(n);
    chk("alu_lat", n, 5);
    chk("alu_ret", O_retired, 1);

    I_opcode = 4'h8;
    n = 0;
    repeat (4) begin cyc(); n++; end
    chk("load_in_mem", O_enmem, 1);
    I_memack = 0;
    repeat (3) begin
      cyc(); n++;
      chk("load_memreq", O_memreq, 1);
      chk("load_memwe", O_memwe, 0);
    end
    I_memack = 1;
    until_fetch(k);
    chk("load_lat", n + k, 9);

    I_opcode = 4'h9;
    repeat (4) cyc();
    chk("store_memwe", O_memwe, 1);
    until_fetch(k);
    chk("store_lat", 4 + k, 5);

    I_opcode = 4'hA; I_brtaken = 1;
    repeat (3) cyc();
    chk("br_taken_pcload", O_pcload, 1);
    until_fetch(k);
    chk("br_taken_lat", 3 + k, 4);
    I_brtaken = 0;
    repeat (3) cyc();
    chk("br_nt_pcload", O_pcload, 0);
    until_fetch(k);
    chk("br_nt_lat", 3 + k, 4);

    I_opcode = 4'hB;
    repeat (3) cyc();
    chk("jump_pcload", O_pcload, 1);
    until_fetch(k);
    chk("jump_lat", 3 + k, 4);

    I_opcode = 4'h0;
    until_fetch(n);
    chk("nop_lat", n, 2);
    chk("ret_after_7", O_retired, 7);

    I_opcode = 4'hD;
    cyc();
    chk("illegal_pulse", O_illegal, 1);
    cyc();
    chk("illegal_to_fetch", O_enfetch, 1);
    chk("illegal_ret", O_retired, 8);

    I_opcode = 4'hF;
    cyc(); cyc();
    chk("halted", O_halted, 1);
    repeat (6) begin I_memack = ~I_memack; cyc(); end
    chk("halt_held", O_halted, 1);
    chk("halt_ret", O_retired, 8);

    I_reset = 1; I_memack = 0; I_opcode = 4'h0;
    cyc();
    I_reset = 0;
    chk("halt_rst_fetch", O_enfetch, 1);
    chk("halt_rst_ret", O_retired, 0);

    repeat (15) cyc();
    chk("tmo_c16_fetch", O_enfetch, 1);
    chk("tmo_c16_err", O_buserr, 0);
    cyc();
    chk("tmo_halt", O_halted, 1);
    chk("tmo_buserr", O_buserr, 1);

    I_reset = 1;
    cyc();
    I_reset = 0;
    chk("tmo_rst_err", O_buserr, 0);
    repeat (15) cyc();
    I_memack = 1;
    cyc();
    chk("ack16_decode", O_endec, 1);
    chk("ack16_err", O_buserr, 0);
    cyc();
    chk("ack16_ret", O_retired, 1);

    I_opcode = 4'h8;
    repeat (4) cyc();
    I_memack = 0;
    repeat (3) cyc();
    I_reset = 1;
    cyc();
    I_reset = 0; I_memack = 1;
    chk("midmem_rst_fetch", O_enfetch, 1);
    chk("midmem_rst_mem", O_enmem, 0);
    chk("midmem_rst_ret", O_retired, 0);

    w_rst = 0;
    repeat (30) cyc();
    chk("wrap_pre", w_ret, 15);
    repeat (2) cyc();
    chk("wrap_zero", w_ret, 0);
    repeat (2) cyc();
    chk("wrap_one", w_ret, 1);

    m_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Opcode-aware multi-cycle sequencer for the single-issue CPU datapath. It steps each instruction through fetch, decode, register read, ALU, memory and write-back, and skips the phases an opcode does not need. It waits on a memory ready handshake and detects bus timeouts. It also counts retired instructions. It replaces fixed-rotation sequencing and drives the same per-stage enables, plus the PC, IR and memory control strobes.

## Interface
- MEM_TIMEOUT, 16: maximum cycles a memory request (fetch or data) may wait for I_memack before bus error.
- CNT_W, 16: width of retired-instruction counter.

- I_clk  in  1  clock, all state on rising edge
- I_reset  in  1  synchronous, active-high reset
- I_opcode  in  4  opcode from IR; sampled only in DECODE
- I_brtaken  in  1  branch condition from ALU flags; sampled only in ALU cycle of BRANCH
- I_memack  in  1  memory ready; completes current request in same cycle
- O_enfetch, O_endec, O_enrgrd, O_enalu, O_enmem, O_enrgwr  out  1 each  stage enables, one-hot with state
- O_memreq  out  1  memory request (FETCH or MEM state)
- O_memwe  out  1  write strobe (MEM state, STORE only)
- O_irload  out  1  load IR (FETCH & I_memack)
- O_pcinc  out  1  PC+1 (FETCH & I_memack)
- O_pcload  out  1  load PC from ALU result
- O_illegal  out  1  one-cycle pulse in DECODE on undefined opcode
- O_halted  out  1  high while in HALT
- O_buserr  out  1  sticky bus-timeout flag, cleared only by reset
- O_retired  out  CNT_W  retired-instruction count

## Operation
- States: FETCH, DECODE, REGRD, ALU, MEM, WB, HALT. The state register is one-hot. The stage enables are decoded directly from it, and HALT drives no stage enable.
- Opcode classes, latched into a class register in DECODE:
  - 0000 NOP
  - 0001–0111 ALU
  - 1000 LOAD
  - 1001 STORE
  - 1010 BRANCH
  - 1011 JUMP
  - 1111 HALT
  - 1100–1110 illegal: O_illegal pulse, then treated as NOP
- Paths:
  - ALU: FETCH→DECODE→REGRD→ALU→WB→FETCH
  - LOAD: FETCH→DECODE→REGRD→ALU→MEM→WB→FETCH
  - STORE: FETCH→DECODE→REGRD→ALU→MEM→FETCH
  - BRANCH/JUMP: FETCH→DECODE→REGRD→ALU→FETCH
  - NOP/illegal: FETCH→DECODE→FETCH
  - HALT: FETCH→DECODE→HALT, held until reset
- FETCH and MEM hold while I_memack=0. They advance on the cycle I_memack=1.
- O_pcload is combinational in the ALU state. It is high for JUMP always, and for BRANCH when I_brtaken=1.
- Wait counter:
  - Clears on entry to FETCH or MEM and increments each cycle without ack.
  - If the cycle with count = MEM_TIMEOUT-1 ends without ack: next state HALT and O_buserr set.
  - Ack on that same cycle wins: normal advance, no error.
- O_retired increments on each transition into FETCH from DECODE, WB, MEM or ALU. Entering HALT does not count. It wraps from 2^CNT_W-1 to 0.

## Timing
- Reset takes effect on the next edge and overrides everything, including mid-wait and HALT. Reset values:
  - state FETCH, so O_enfetch=1 and O_memreq=1
  - O_buserr=0, O_retired=0, wait counter 0, class register NOP
  - all other outputs 0
- With zero-wait memory (I_memack held 1), instruction latency is:
  - NOP: 2 cycles
  - BRANCH/JUMP: 4
  - ALU: 5
  - STORE: 5
  - LOAD: 6
- Each memory wait cycle adds one cycle.
- O_memreq stays high continuously from state entry until the ack cycle inclusive. O_memwe follows the same timing.
- O_retired changes on the edge where state becomes FETCH, so it is visible in the first FETCH cycle of the next instruction.
- I_opcode is ignored outside DECODE. I_brtaken is ignored outside the ALU cycle of BRANCH.

## Test plan
- Reset, then I_memack=1 with opcode 0001: state sequence FETCH, DECODE, REGRD, ALU, WB, FETCH. O_retired=1 at the sixth cycle. O_irload/O_pcinc pulse only in cycle 1.
- LOAD with I_memack low for 3 cycles in MEM: MEM lasts 4 cycles with O_memreq high throughout and O_memwe=0, then WB. Total 9 cycles.
- BRANCH with I_brtaken=1, then BRANCH with 0: O_pcload=1 in the first ALU cycle and 0 in the second. Both return to FETCH after 4 cycles.
- Opcode 1101: O_illegal pulses in DECODE, next state FETCH, O_retired increments. Opcode 1111 then: O_halted=1 held, I_memack toggling has no effect, and reset returns to FETCH with O_retired=0.
- FETCH with I_memack=0 for 16 cycles (MEM_TIMEOUT=16): HALT entered on the 17th cycle and O_buserr=1. A repeat run with ack on cycle 16 advances to DECODE and O_buserr stays 0.
- Preload via 65535 NOPs (CNT_W=16): O_retired wraps to 0. Reset asserted mid-MEM wait gives FETCH next cycle with all counters cleared.
